// File: rtl/mem_stage_if.sv
// Data-memory port of the memory-access stage.
//
// Handshake: the stage raises exactly one of dmem_read/dmem_write together
// with dmem_address, dmem_mbe and dmem_wdata. It holds all of them stable
// until the memory answers with a single-cycle dmem_resp pulse. dmem_rdata
// is only meaningful in the cycle dmem_resp is high. A dmem_resp that
// arrives while no request is raised is ignored.
//
// Modports:
//   master - the mem_stage side (drives the request, samples the response)
//   slave  - the memory side (samples the request, drives the response)
interface mem_stage_if;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_address, dmem_read, dmem_write, dmem_mbe, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_address, dmem_read, dmem_write, dmem_mbe, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage of the CP1 pipelined RV32I core (EX/MEM -> MEM/WB).
//
// Issues data-memory loads and stores, aligns store data and byte enables,
// sign/zero-extends load data and registers the writeback result. It stalls
// the upstream pipeline while an access is outstanding. Non-memory ops
// forward alu_out with a latency of one cycle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_*              EX/MEM control and data fields
//   dmem              data-memory request/response (mem_stage_if.master)
//   mem_stall         freezes the upstream stages and the EX/MEM latch
//   wb_*              MEM/WB latch contents
//   stall_cycles      saturating count of cycles with mem_stall high
//   wb_misalign       misaligned-access flag (only with MEM_MISALIGN_TRAP_EN)
//   dbg_state         current FSM state (0 = IDLE, 1 = BUSY)
//
// Build option MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are not
// issued and are flagged on wb_misalign instead. When the option is off, the
// low address bits are dropped for half/word accesses.
module mem_stage #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_dmem_read,
  input  logic                   in_dmem_write,
  input  logic [2:0]             in_funct3,
  input  logic                   in_load_regfile,
  input  logic [4:0]             in_rd,
  input  logic [31:0]            in_alu_out,
  input  logic [31:0]            in_rs2_out,
  mem_stage_if.master            dmem,
  output logic                   mem_stall,
  output logic                   wb_valid,
  output logic [4:0]             wb_rd,
  output logic                   wb_load_regfile,
  output logic [31:0]            wb_data,
  output logic [STALL_CNT_W-1:0] stall_cycles,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                   wb_misalign,
`endif
  output logic                   dbg_state
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            addr_q, addr_d;     // full effective address
  logic [3:0]             mbe_q, mbe_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   rd_req_q, rd_req_d;
  logic                   wr_req_q, wr_req_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [4:0]             rd_q, rd_d;
  logic                   lreg_q, lreg_d;
  logic                   wb_valid_q, wb_valid_d;
  logic [4:0]             wb_rd_q, wb_rd_d;
  logic                   wb_lreg_q, wb_lreg_d;
  logic [31:0]            wb_data_q, wb_data_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                   misalign_q, misalign_d;
  logic                   trap;
`endif

  logic        is_mem, issue;
  logic        in_byte, in_half;
  logic [1:0]  in_off;
  logic [3:0]  in_mbe;
  logic [31:0] in_wdata;
  logic [31:0] load_val;

  // Access size from funct3[1:0]: 00 byte, 01 half, anything else is a word
  // (this also covers the undefined encodings).
  always_comb begin
    is_mem  = in_valid & (in_dmem_read | in_dmem_write);
    in_byte = (in_funct3[1:0] == 2'b00);
    in_half = (in_funct3[1:0] == 2'b01);
    in_off  = in_alu_out[1:0];
    if (in_byte) begin
      in_mbe   = 4'b0001 << in_off;
      in_wdata = in_rs2_out << {in_off, 3'b000};
    end else if (in_half) begin
      in_mbe   = 4'b0011 << {in_off[1], 1'b0};
      in_wdata = in_rs2_out << {in_off[1], 4'b0000};
    end else begin
      in_mbe   = 4'b1111;
      in_wdata = in_rs2_out;
    end
`ifdef MEM_MISALIGN_TRAP_EN
    trap  = is_mem & ((in_half & in_off[0]) | (!in_byte && !in_half && in_off != 2'b00));
    issue = is_mem & !trap;
`else
    issue = is_mem;
`endif
  end

  // Load extraction uses the offset latched at issue; funct3[2] selects zero-extension.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        load_val = {24'h0, dmem.dmem_rdata[{addr_q[1:0], 3'b000} +: 8]};
        if (!funct3_q[2] && load_val[7]) load_val[31:8] = 24'hFF_FFFF;
      end
      2'b01: begin
        load_val = {16'h0, dmem.dmem_rdata[{addr_q[1], 4'b0000} +: 16]};
        if (!funct3_q[2] && load_val[15]) load_val[31:16] = 16'hFFFF;
      end
      default: load_val = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mbe_d      = mbe_q;
    wdata_d    = wdata_q;
    rd_req_d   = rd_req_q;
    wr_req_d   = wr_req_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    lreg_d     = lreg_q;
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_lreg_d  = wb_lreg_q;
    wb_data_d  = wb_data_q;
    mem_stall  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (issue) begin
          mem_stall  = 1'b1;
          state_d    = BUSY;
          addr_d     = in_alu_out;
          mbe_d      = in_mbe;
          wdata_d    = in_wdata;
          rd_req_d   = in_dmem_read;               // read wins over write
          wr_req_d   = in_dmem_write & ~in_dmem_read;
          funct3_d   = in_funct3;
          rd_d       = in_rd;
          lreg_d     = in_load_regfile;
          wb_valid_d = 1'b0;
          wb_lreg_d  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        end else if (trap) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = in_rd;
          wb_lreg_d  = 1'b0;
          wb_data_d  = in_alu_out;
          misalign_d = 1'b1;
`endif
        end else if (in_valid) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = in_rd;
          wb_lreg_d  = in_load_regfile;
          wb_data_d  = in_alu_out;
        end else begin
          wb_valid_d = 1'b0;
          wb_lreg_d  = 1'b0;
        end
      end
      BUSY: begin
        mem_stall  = ~dmem.dmem_resp;
        wb_valid_d = 1'b0;
        if (dmem.dmem_resp) begin
          state_d    = IDLE;
          rd_req_d   = 1'b0;
          wr_req_d   = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_lreg_d  = rd_req_q ? lreg_q : 1'b0;
          wb_data_d  = rd_req_q ? load_val : addr_q;
        end
      end
      default: state_d = IDLE;
    endcase
    stall_d = (mem_stall && stall_q != {STALL_CNT_W{1'b1}}) ? stall_q + STALL_CNT_W'(1) : stall_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mbe_q      <= '0;
      wdata_q    <= '0;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      funct3_q   <= '0;
      rd_q       <= '0;
      lreg_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_lreg_q  <= 1'b0;
      wb_data_q  <= '0;
      stall_q    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mbe_q      <= mbe_d;
      wdata_q    <= wdata_d;
      rd_req_q   <= rd_req_d;
      wr_req_q   <= wr_req_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      lreg_q     <= lreg_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_lreg_q  <= wb_lreg_d;
      wb_data_q  <= wb_data_d;
      stall_q    <= stall_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign dmem.dmem_address = {addr_q[31:2], 2'b00};
  assign dmem.dmem_read    = rd_req_q;
  assign dmem.dmem_write   = wr_req_q;
  assign dmem.dmem_mbe     = mbe_q;
  assign dmem.dmem_wdata   = wdata_q;
  assign wb_valid          = wb_valid_q;
  assign wb_rd             = wb_rd_q;
  assign wb_load_regfile   = wb_lreg_q;
  assign wb_data           = wb_data_q;
  assign stall_cycles      = stall_q;
  assign dbg_state         = state_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign wb_misalign       = misalign_q;
`endif
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the CP1 pipelined RV32I core. Sits between the EX/MEM latch and the MEM/WB latch.
- Consumes the EX/MEM control-word fields (dmem_read, dmem_write, funct3, load_regfile) and data-word fields (alu_out, rs2_out, rd).
- Drives the data-memory request/response handshake, aligns store data and byte enables, and sign/zero-extends load data.
- Registers the writeback result and raises a pipeline stall while a memory access is outstanding.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  EX/MEM holds a valid instruction.
- in_dmem_read  in  1  control word dmem_read.
- in_dmem_write  in  1  control word dmem_write.
- in_funct3  in  3  load_funct3_t / store_funct3_t encoding.
- in_load_regfile  in  1  control word load_regfile.
- in_rd  in  5  destination register.
- in_alu_out  in  32  effective address, or ALU result for non-memory ops.
- in_rs2_out  in  32  store data.
- dmem_address  out  32  word-aligned address {addr[31:2],2'b00}.
- dmem_read  out  1  read request.
- dmem_write  out  1  write request.
- dmem_mbe  out  4  byte mask.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_rdata  in  32  read data.
- dmem_resp  in  1  access complete.
- mem_stall  out  1  freeze upstream stages and the EX/MEM latch.
- wb_valid  out  1  MEM/WB entry valid.
- wb_rd  out  5  destination register.
- wb_load_regfile  out  1  regfile write enable.
- wb_data  out  32  load result or forwarded alu_out.
- stall_cycles  out  STALL_CNT_W  saturating count of cycles mem_stall was high.

Behaviour:
- FSM states: IDLE, BUSY.
- is_mem = in_valid & (in_dmem_read | in_dmem_write).
- Reset: state=IDLE; dmem_read=dmem_write=0; dmem_mbe=0; dmem_address=0; dmem_wdata=0; wb_valid=0; wb_load_regfile=0; wb_rd=0; wb_data=0; stall_cycles=0.
- Reset mid-access: request drops at that edge. Any later dmem_resp while IDLE is ignored.
- Non-memory op (in_valid & !is_mem) in IDLE:
  - 1-cycle latency; next edge loads wb_valid=1, wb_data=in_alu_out, wb_rd/wb_load_regfile from inputs.
  - mem_stall=0.
- in_valid=0 in IDLE: next edge loads wb_valid=0 and wb_load_regfile=0 (bubble).
- IDLE with is_mem:
  - mem_stall=1 combinationally.
  - Next edge: state→BUSY; register dmem_address, dmem_mbe, dmem_wdata, and assert dmem_read or dmem_write; latch rd, funct3, addr[1:0], load_regfile.
  - wb_valid←0 that edge.
- BUSY:
  - Request outputs held stable until dmem_resp=1.
  - mem_stall = !dmem_resp.
  - On the dmem_resp edge: state→IDLE; dmem_read/dmem_write←0; wb_valid←1.
    - Load: wb_data←extracted value.
    - Store: wb_data←address, wb_load_regfile←0.
  - In the cycle dmem_resp=1, mem_stall=0, so the next EX/MEM entry is accepted by IDLE on the following cycle. There are no back-to-back issues from BUSY.
- dmem_read and dmem_write never both high. If both inputs are set, read wins.
- Store lane rules, with o = addr[1:0]:
  - sb: mbe=4'b0001<<o; wdata=rs2<<(8*o).
  - sh: mbe=4'b0011<<{o[1],1'b0}; wdata=rs2<<(16*o[1]).
  - sw: mbe=4'b1111; wdata=rs2.
- Load mbe: lb/lbu use the byte mask above, lh/lhu the half mask, lw 4'b1111.
- Load extract:
  - lb/lbu: byte rdata[8*o+:8], sign- or zero-extended.
  - lh/lhu: half rdata[16*o[1]+:16], sign- or zero-extended.
  - lw: rdata.
- Undefined funct3: treated as word access.
- stall_cycles increments each cycle mem_stall=1, saturates at all-ones, and never wraps.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned means lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0.
  - A misaligned access is not issued; there is no BUSY state and no stall.
  - Next edge: wb_valid=1, wb_load_regfile=0, wb_data=in_alu_out, and output wb_misalign (1 bit, added port) =1 for one cycle.
  - wb_misalign resets to 0.
- Undefined:
  - No wb_misalign port.
  - Low address bits are dropped for half/word (forced alignment: half uses o[1], word uses offset 0) and the access proceeds normally.

Test Plan:
- Non-memory op: addi result in_alu_out=0x0000_1234, rd=5 → next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, no stall, dmem idle.
- sb with addr=0x8000_0003, rs2=0x0000_00AB, dmem_resp after 3 cycles:
  - dmem_address=0x8000_0000, mbe=4'b1000, wdata=0xAB00_0000 held until resp.
  - mem_stall high 3 cycles; wb_load_regfile=0; stall_cycles=3.
- lb addr=0x...02 with rdata=0x00F0_0000 → wb_data=0xFFFF_FFF0. Same access as lbu → 0x0000_00F0.
- lh addr=0x...02 with rdata=0x8001_0000 → mbe=4'b1100, wb_data=0xFFFF_8001. Same access as lhu → 0x0000_8001.
- rst asserted while BUSY on an lw → next cycle dmem_read=0, wb_valid=0, state IDLE. A dmem_resp pulse one cycle later produces no wb_valid.
- With MEM_MISALIGN_TRAP_EN, lw addr=0x...01 → no dmem_read; next cycle wb_misalign=1, wb_load_regfile=0, mem_stall never high. Without the macro, the same access reads 0x...00 with mbe=4'b1111.
